// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencing controller.
// Optional debug read port is enabled by defining ALU_SEQ_DBG_EN.
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 4;
  localparam int IDX_W  = 2;

  typedef logic [2:0] opc_t;

  localparam opc_t OPC_NEG  = 3'b000;
  localparam opc_t OPC_INC  = 3'b001;
  localparam opc_t OPC_ADD  = 3'b010;
  localparam opc_t OPC_ADDH = 3'b011;
  localparam opc_t OPC_AND  = 3'b100;
  localparam opc_t OPC_OR   = 3'b101;
  localparam opc_t OPC_CAT  = 3'b110;
  localparam opc_t OPC_LDI  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              z;
    logic              n;
  } res_t;

  function automatic res_t ldi_result(
    input logic [DATA_W-1:0] imm
  );
    res_t r;
    r.val = imm;
    r.z   = (imm == '0);
    r.n   = imm[DATA_W-1];
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction valid/ready handshake into the sequencing controller.
// Debug read port (ALU_SEQ_DBG_EN) is not carried here.
interface alu_seq_ctrl_if;
  import alu_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  opc_t              in_opc;
  logic [IDX_W-1:0]  in_dst;
  logic [IDX_W-1:0]  in_srca;
  logic [IDX_W-1:0]  in_srcb;
  logic              in_cin;
  logic [DATA_W-1:0] in_imm;

  modport master (
    output in_valid,
    output in_opc,
    output in_dst,
    output in_srca,
    output in_srcb,
    output in_cin,
    output in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_opc,
    input  in_dst,
    input  in_srca,
    input  in_srcb,
    input  in_cin,
    input  in_imm,
    output in_ready
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// Register file: two async reads, one sync write, zeroed on reset.
// ALU_SEQ_DBG_EN adds a third combinational read port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int REGS = NREGS,
  parameter int W    = DATA_W,
  parameter int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
`endif
);

  logic [W-1:0] mem [REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

`ifdef ALU_SEQ_DBG_EN
  assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer around the 16-bit ALU: IDLE -> EXEC -> WB, one op per 3 cycles.
// ALU_SEQ_DBG_EN exposes dbg_addr/dbg_data as an extra RF read port.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int REGS = NREGS,
  parameter int W    = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_ctrl_if.slave    instr,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_c,
  output opc_t             alu_opc,
  input  logic [W-1:0]     alu_w,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [W-1:0]     dbg_data
`endif
);

  state_t           state;
  logic [IDX_W-1:0] dst_q;
  logic [W-1:0]     imm_q;
  logic [W-1:0]     res_q;
  logic             res_z;
  logic             res_n;
  logic [W-1:0]     rd_a;
  logic [W-1:0]     rd_b;
  logic             accept;
  res_t             ldi;

  assign instr.in_ready = (state == IDLE);
  assign accept = instr.in_valid && instr.in_ready;
  assign ldi = ldi_result(imm_q);

  alu_seq_regfile #(
    .REGS (REGS),
    .W    (W),
    .AW   (IDX_W)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr.in_srca),
    .ra_data  (rd_a),
    .rb_addr  (instr.in_srcb),
    .rb_data  (rd_b),
    .we       (state == WB),
    .wa       (dst_q),
    .wd       (res_q)
`ifdef ALU_SEQ_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dst_q   <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      res_z   <= 1'b0;
      res_n   <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_c   <= 1'b0;
      alu_opc <= OPC_LDI;
      done    <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            dst_q   <= instr.in_dst;
            imm_q   <= instr.in_imm;
            alu_a   <= rd_a;
            alu_b   <= rd_b;
            alu_c   <= instr.in_cin;
            alu_opc <= instr.in_opc;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // LDI bypasses the ALU, which drives 0 for this opcode
          if (alu_opc == OPC_LDI) begin
            res_q <= ldi.val;
            res_z <= ldi.z;
            res_n <= ldi.n;
          end else begin
            res_q <= alu_w;
            res_z <= alu_zer;
            res_n <= alu_neg;
          end
          alu_opc <= OPC_LDI;
          done    <= 1'b1;
          state   <= WB;
        end
        WB: begin
          flag_z <= res_z;
          flag_n <= res_n;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the team ALU.
// Define ALU_SEQ_DBG_EN to build against the debug-port variant.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_c;
  opc_t        alu_opc;
  logic [15:0] alu_w;
  logic        alu_zer;
  logic        alu_neg;
  logic        done;
  logic        flag_z;
  logic        flag_n;
`ifdef ALU_SEQ_DBG_EN
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;
`endif

  int tests;
  int fails;

  alu_seq_ctrl_if ifc ();

  alu_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (ifc),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_opc  (alu_opc),
    .alu_w    (alu_w),
    .alu_zer  (alu_zer),
    .alu_neg  (alu_neg),
    .done     (done),
    .flag_z   (flag_z),
    .flag_n   (flag_n)
`ifdef ALU_SEQ_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  // team ALU model
  logic [16:0] sum17;
  always_comb begin
    sum17 = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_c};
    case (alu_opc)
      OPC_NEG:  alu_w = 16'd0 - alu_a;
      OPC_INC:  alu_w = alu_a + 16'd1;
      OPC_ADD:  alu_w = sum17[15:0];
      OPC_ADDH: alu_w = sum17[16:1];
      OPC_AND:  alu_w = alu_a & alu_b;
      OPC_OR:   alu_w = alu_a | alu_b;
      OPC_CAT:  alu_w = {alu_a[15:8], alu_b[7:0]};
      default:  alu_w = 16'd0;
    endcase
    alu_zer = (alu_w == 16'd0);
    alu_neg = alu_w[15];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(
    input opc_t o, input logic [1:0] d,
    input logic [1:0] a, input logic [1:0] b,
    input logic c, input logic [15:0] im
  );
    int n;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (ifc.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: in_ready=%b want 1", ifc.in_ready);
    end
    ifc.in_opc   = o;
    ifc.in_dst   = d;
    ifc.in_srca  = a;
    ifc.in_srcb  = b;
    ifc.in_cin   = c;
    ifc.in_imm   = im;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic run(
    input opc_t o, input logic [1:0] d,
    input logic [1:0] a, input logic [1:0] b,
    input logic c, input logic [15:0] im
  );
    issue(o, d, a, b, c, im);
    repeat (2) @(negedge clk);
  endtask

  // OR r,r -> r leaves r unchanged and exposes it on alu_a
  task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
    issue(OPC_OR, r, r, r, 1'b0, 16'h0);
    @(negedge clk);
    v = alu_a;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (ifc.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready: got %b want 1", ifc.in_ready);
    end
    tests++;
    if (alu_opc !== OPC_LDI) begin
      fails++;
      $display("FAIL rst_opc: got %b want 111", alu_opc);
    end
    tests++;
    if ({flag_z, flag_n, done} !== 3'b000) begin
      fails++;
      $display("FAIL rst_flags: z/n/done=%b want 000", {flag_z, flag_n, done});
    end
    tests++;
    if ({alu_a, alu_b, alu_c} !== 33'd0) begin
      fails++;
      $display("FAIL rst_operands: a=%h b=%h c=%b want 0", alu_a, alu_b, alu_c);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      tests++;
      if (v !== 16'h0000) begin
        fails++;
        $display("FAIL rst_rf r%0d: got %h want 0000", r, v);
      end
    end
  endtask

  task automatic test_neg;
    logic [15:0] v;
    issue(OPC_LDI, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0005);
    @(negedge clk);
    tests++;
    if ({done, ifc.in_ready} !== 2'b00) begin
      fails++;
      $display("FAIL ldi_exec: done/ready=%b want 00", {done, ifc.in_ready});
    end
    @(negedge clk);
    tests++;
    if ({done, ifc.in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL ldi_wb: done/ready=%b want 10", {done, ifc.in_ready});
    end
    @(negedge clk);
    tests++;
    if ({done, ifc.in_ready, flag_z, flag_n} !== 4'b0100) begin
      fails++;
      $display("FAIL ldi_idle: done/ready/z/n=%b want 0100",
               {done, ifc.in_ready, flag_z, flag_n});
    end
    issue(OPC_NEG, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0);
    @(negedge clk);
    tests++;
    if ({alu_opc, alu_a, done} !== {OPC_NEG, 16'h0005, 1'b0}) begin
      fails++;
      $display("FAIL neg_exec: opc=%b a=%h done=%b want 000 0005 0",
               alu_opc, alu_a, done);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL neg_done: got %b want 1", done);
    end
    @(negedge clk);
    tests++;
    if ({flag_z, flag_n, alu_opc} !== {1'b0, 1'b1, OPC_LDI}) begin
      fails++;
      $display("FAIL neg_flags: z=%b n=%b opc=%b want 0 1 111",
               flag_z, flag_n, alu_opc);
    end
    read_reg(2'd2, v);
    tests++;
    if (v !== 16'hFFFB) begin
      fails++;
      $display("FAIL neg_r2: got %h want fffb", v);
    end
  endtask

  task automatic test_logic;
    logic [15:0] v;
    run(OPC_LDI, 2'd0, 2'd0, 2'd0, 1'b0, 16'h00F0);
    run(OPC_LDI, 2'd3, 2'd0, 2'd0, 1'b0, 16'h0F0F);
    run(OPC_AND, 2'd1, 2'd0, 2'd3, 1'b0, 16'h0);
    @(negedge clk);
    tests++;
    if ({flag_z, flag_n} !== 2'b10) begin
      fails++;
      $display("FAIL and_flags: z/n=%b want 10", {flag_z, flag_n});
    end
    read_reg(2'd1, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL and_r1: got %h want 0000", v);
    end
    run(OPC_CAT, 2'd2, 2'd3, 2'd0, 1'b0, 16'h0);
    @(negedge clk);
    tests++;
    if ({flag_z, flag_n} !== 2'b00) begin
      fails++;
      $display("FAIL cat_flags: z/n=%b want 00", {flag_z, flag_n});
    end
    read_reg(2'd2, v);
    tests++;
    if (v !== 16'h0FF0) begin
      fails++;
      $display("FAIL cat_r2: got %h want 0ff0", v);
    end
  endtask

  task automatic test_add_inc;
    logic [15:0] v;
    run(OPC_LDI, 2'd1, 2'd0, 2'd0, 1'b0, 16'h7FFF);
    run(OPC_LDI, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0000);
    tests++;
    if ({flag_z, flag_n} !== 2'b00) begin
      fails++;
      $display("FAIL ldi_flags_prev: z/n=%b want 00", {flag_z, flag_n});
    end
    @(negedge clk);
    tests++;
    if ({flag_z, flag_n} !== 2'b10) begin
      fails++;
      $display("FAIL ldi_zero_flags: z/n=%b want 10", {flag_z, flag_n});
    end
    run(OPC_ADD, 2'd1, 2'd1, 2'd2, 1'b1, 16'h0);
    run(OPC_INC, 2'd1, 2'd1, 2'd0, 1'b0, 16'h0);
    tests++;
    if (alu_a !== 16'h8000) begin
      fails++;
      $display("FAIL inc_operand: got %h want 8000", alu_a);
    end
    @(negedge clk);
    tests++;
    if ({flag_z, flag_n} !== 2'b01) begin
      fails++;
      $display("FAIL inc_flags: z/n=%b want 01", {flag_z, flag_n});
    end
    read_reg(2'd1, v);
    tests++;
    if (v !== 16'h8001) begin
      fails++;
      $display("FAIL inc_r1: got %h want 8001", v);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] imms [6];
    logic [1:0]  dsts [6];
    logic [15:0] exp  [4];
    logic [15:0] v;
    int          k;
    int          bad;
    logic        rdy;
    imms = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    dsts = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp  = '{16'h5555, 16'h6666, 16'h3333, 16'h4444};
    k   = 0;
    bad = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      rdy = ifc.in_ready;
      if (rdy !== (c % 3 == 0)) bad++;
      ifc.in_opc   = OPC_LDI;
      ifc.in_dst   = dsts[k < 6 ? k : 5];
      ifc.in_srca  = 2'd0;
      ifc.in_srcb  = 2'd0;
      ifc.in_cin   = 1'b0;
      ifc.in_imm   = imms[k < 6 ? k : 5];
      ifc.in_valid = 1'b1;
      @(posedge clk);
      if (rdy === 1'b1) k++;
    end
    #1 ifc.in_valid = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL b2b_ready_pattern: %0d cycles off, want 0", bad);
    end
    tests++;
    if (k !== 6) begin
      fails++;
      $display("FAIL b2b_accepts: got %0d want 6", k);
    end
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      tests++;
      if (v !== exp[r]) begin
        fails++;
        $display("FAIL b2b_r%0d: got %h want %h", r, v, exp[r]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    int          pulses;
    issue(OPC_LDI, 2'd2, 2'd0, 2'd0, 1'b0, 16'h1234);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({done, ifc.in_ready, alu_opc} !== {1'b0, 1'b1, OPC_LDI}) begin
      fails++;
      $display("FAIL midrst_state: done=%b ready=%b opc=%b want 0 1 111",
               done, ifc.in_ready, alu_opc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) pulses++;
    end
    tests++;
    if (pulses !== 0 || ifc.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_idle: done pulses=%0d ready=%b want 0 1",
               pulses, ifc.in_ready);
    end
    read_reg(2'd2, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL midrst_r2: got %h want 0000", v);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_opc   = OPC_LDI;
    ifc.in_dst   = 2'd0;
    ifc.in_srca  = 2'd0;
    ifc.in_srcb  = 2'd0;
    ifc.in_cin   = 1'b0;
    ifc.in_imm   = 16'h0;
`ifdef ALU_SEQ_DBG_EN
    dbg_addr     = 2'd0;
`endif
    test_reset;
    test_neg;
    test_logic;
    test_add_inc;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
